// File: rtl/sdfa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdfa_pkg
// Description : Shared defaults and FSM state encoding for the SDFA back-end.
// Revision    : 1.0 - initial release
// ============================================================================
package sdfa_pkg;

    localparam int SDFA_NUM_CLASSES = 10;
    localparam int SDFA_VALUE_W     = 10;
    localparam int SDFA_LABEL_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sdfa_argmax_scorer_if.sv
`default_nettype none
// ============================================================================
// Module      : sdfa_argmax_scorer_if
// Description : Result burst, label push, prediction and statistics bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdfa_argmax_scorer_if #(
    parameter int VALUE_W = 10,
    parameter int LABEL_W = 4,
    parameter int CNT_W   = 16
);
    logic               res_valid;
    logic [VALUE_W-1:0] res_value;
    logic               label_valid;
    logic [LABEL_W-1:0] label;
    logic               label_ready;
    logic               clr_stats;
    logic               pred_valid;
    logic [LABEL_W-1:0] pred_class;
    logic [VALUE_W-1:0] pred_value;
    logic               pred_has_label;
    logic               pred_correct;
    logic [CNT_W-1:0]   stat_images;
    logic [CNT_W-1:0]   stat_correct;
    logic               err_burst;
    logic               err_label_ovf;

    modport master (
        output res_valid, res_value, label_valid, label, clr_stats,
        input  label_ready, pred_valid, pred_class, pred_value, pred_has_label,
               pred_correct, stat_images, stat_correct, err_burst, err_label_ovf
    );

    modport slave (
        input  res_valid, res_value, label_valid, label, clr_stats,
        output label_ready, pred_valid, pred_class, pred_value, pred_has_label,
               pred_correct, stat_images, stat_correct, err_burst, err_label_ovf
    );
endinterface
`default_nettype wire

// File: rtl/sdfa_label_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sdfa_label_fifo
// Description : Synchronous FIFO with full/empty flags and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module sdfa_label_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push_i,
    input  wire logic [WIDTH-1:0]         din_i,
    input  wire logic                     pop_i,
    output logic      [WIDTH-1:0]         dout_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic      [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign dout_o    = mem_q[rd_ptr_q];
    // Flags come from the current count only: no bypass on empty, no pop-makes-room on full.
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/sdfa_argmax_scorer.sv
`default_nettype none
// ============================================================================
// Module      : sdfa_argmax_scorer
// Description : Signed argmax over a class-score burst, scored against queued labels.
// Revision    : 1.0 - initial release
// ============================================================================
module sdfa_argmax_scorer
    import sdfa_pkg::*;
#(
    parameter int NUM_CLASSES = SDFA_NUM_CLASSES,
    parameter int VALUE_W     = SDFA_VALUE_W,
    parameter int LABEL_W     = SDFA_LABEL_W,
    parameter int ROT         = 1,
    parameter int LBL_DEPTH   = 8,
    parameter int CNT_W       = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    sdfa_argmax_scorer_if.slave sif
);
    localparam int               BEAT_W     = $clog2(NUM_CLASSES + 2);
    localparam logic [LABEL_W-1:0] CLS_FIRST = LABEL_W'(ROT % NUM_CLASSES);
    localparam logic [LABEL_W-1:0] CLS_LAST  = LABEL_W'(NUM_CLASSES - 1);
    localparam logic [BEAT_W-1:0]  BEAT_FULL = BEAT_W'(NUM_CLASSES);
    localparam logic [BEAT_W-1:0]  BEAT_SAT  = BEAT_W'(NUM_CLASSES + 1);
    localparam logic [1:0]         S_IDLE    = 2'(ST_IDLE);
    localparam logic [1:0]         S_ACCUM   = 2'(ST_ACCUM);
    localparam logic [1:0]         S_EMIT    = 2'(ST_EMIT);

    logic [1:0]         state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [LABEL_W-1:0] cls_q, cls_d;
    logic [LABEL_W-1:0] arg_q, arg_d;
    logic [VALUE_W-1:0] max_q, max_d;
    logic [LABEL_W-1:0] hold_cls_q;
    logic [VALUE_W-1:0] hold_val_q;
    logic               hold_has_q, hold_cor_q;
    logic [CNT_W-1:0]   images_q, correct_q;
    logic               err_burst_q, err_ovf_q;

    logic               w_pop, w_burst_err, w_emit, w_has, w_cor;
    logic               w_fifo_full, w_fifo_empty;
    logic [LABEL_W-1:0] w_fifo_head;
    logic [$clog2(LBL_DEPTH):0] w_fifo_count_unused;

    function automatic logic [LABEL_W-1:0] next_cls(input logic [LABEL_W-1:0] c);
        return (c == CLS_LAST) ? '0 : c + 1'b1;
    endfunction

    sdfa_label_fifo #(.DEPTH(LBL_DEPTH), .WIDTH(LABEL_W)) u_label_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (sif.label_valid),
        .din_i   (sif.label),
        .pop_i   (w_pop),
        .dout_o  (w_fifo_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count_unused)
    );

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        cls_d       = cls_q;
        arg_d       = arg_q;
        max_d       = max_q;
        w_pop       = 1'b0;
        w_burst_err = 1'b0;
        case (state_q)
            S_ACCUM: begin
                if (sif.res_valid) begin
                    if (beat_q < BEAT_FULL && $signed(sif.res_value) > $signed(max_q)) begin
                        max_d = sif.res_value;
                        arg_d = cls_q;
                    end
                    cls_d = next_cls(cls_q);
                    if (beat_q != BEAT_SAT) beat_d = beat_q + 1'b1;
                end else if (beat_q == BEAT_FULL) begin
                    state_d = S_EMIT;
                end else begin
                    w_burst_err = 1'b1;
                    w_pop       = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_EMIT: begin
                w_pop   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A beat seen outside ACCUM (IDLE or EMIT) always opens a fresh burst.
        if (sif.res_valid && state_q != S_ACCUM) begin
            max_d   = sif.res_value;
            arg_d   = CLS_FIRST;
            cls_d   = next_cls(CLS_FIRST);
            beat_d  = BEAT_W'(1);
            state_d = S_ACCUM;
        end
    end

    assign w_emit = (state_q == S_EMIT);
    assign w_has  = w_emit && !w_fifo_empty;
    assign w_cor  = w_has && (w_fifo_head == arg_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            cls_q      <= '0;
            arg_q      <= '0;
            max_q      <= '0;
            hold_cls_q <= '0;
            hold_val_q <= '0;
            hold_has_q <= 1'b0;
            hold_cor_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cls_q   <= cls_d;
            arg_q   <= arg_d;
            max_q   <= max_d;
            if (w_emit) begin
                hold_cls_q <= arg_q;
                hold_val_q <= max_q;
                hold_has_q <= w_has;
                hold_cor_q <= w_cor;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || sif.clr_stats) begin
            images_q    <= '0;
            correct_q   <= '0;
            err_burst_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            if (w_emit && ~&images_q)         images_q  <= images_q + 1'b1;
            if (w_cor && ~&correct_q)         correct_q <= correct_q + 1'b1;
            if (w_burst_err)                  err_burst_q <= 1'b1;
            if (sif.label_valid && w_fifo_full) err_ovf_q <= 1'b1;
        end
    end

    // During EMIT the live result is shown; afterwards the captured copy holds it.
    assign sif.pred_valid     = w_emit;
    assign sif.pred_class     = w_emit ? arg_q : hold_cls_q;
    assign sif.pred_value     = w_emit ? max_q : hold_val_q;
    assign sif.pred_has_label = w_emit ? w_has : hold_has_q;
    assign sif.pred_correct   = w_emit ? w_cor : hold_cor_q;
    assign sif.label_ready    = !w_fifo_full;
    assign sif.stat_images    = images_q;
    assign sif.stat_correct   = correct_q;
    assign sif.err_burst      = err_burst_q;
    assign sif.err_label_ovf  = err_ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_sdfa_argmax_scorer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdfa_argmax_scorer
// Description : Scoreboard bench for the argmax scorer (defaults, ROT=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdfa_argmax_scorer;
    localparam int NC = 10;
    localparam int VW = 10;
    localparam int LW = 4;
    localparam int CW = 16;

    typedef struct {
        logic [LW-1:0] cls;
        logic [VW-1:0] val;
        logic          has;
        logic          cor;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sdfa_argmax_scorer_if #(.VALUE_W(VW), .LABEL_W(LW), .CNT_W(CW)) sif ();

    sdfa_argmax_scorer #(
        .NUM_CLASSES(NC), .VALUE_W(VW), .LABEL_W(LW),
        .ROT(1), .LBL_DEPTH(8), .CNT_W(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif.slave)
    );

    int   nvec  = 0;
    int   nfail = 0;
    exp_t expq[$];
    int   lblq[$];
    int   m_images, m_correct;
    logic m_eb, m_ovf;
    logic signed [VW-1:0] bv [0:15];

    // Scoreboard: every prediction pulse consumes one expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && sif.pred_valid) begin
            nvec++;
            if (expq.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_pred: got class %0d value %0d, required no prediction",
                         sif.pred_class, $signed(sif.pred_value));
            end else begin
                e = expq.pop_front();
                if ({sif.pred_class, sif.pred_value, sif.pred_has_label, sif.pred_correct}
                    !== {e.cls, e.val, e.has, e.cor}) begin
                    nfail++;
                    $display("FAIL pred: got cls=%0d val=%0d has=%0b cor=%0b, required cls=%0d val=%0d has=%0b cor=%0b",
                             sif.pred_class, $signed(sif.pred_value), sif.pred_has_label,
                             sif.pred_correct, e.cls, $signed(e.val), e.has, e.cor);
                end
            end
        end
    end

    task automatic model_reset();
        lblq.delete();
        m_images = 0; m_correct = 0; m_eb = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_label(input int lab);
        sif.label_valid = 1'b1;
        sif.label = LW'(lab);
        if (lblq.size() < 8) lblq.push_back(lab); else m_ovf = 1'b1;
        @(posedge clk); #1;
        sif.label_valid = 1'b0;
    endtask

    task automatic fill(input int peak_cls, input int peak_val);
        for (int b = 0; b < 16; b++) bv[b] = VW'($urandom_range(0, 100)) - VW'(50);
        bv[(peak_cls + NC - 1) % NC] = VW'(peak_val);
    endtask

    // Drives bv[0..len-1] back to back from the current cycle and queues the expectation.
    task automatic send_burst(input int len);
        int   mx, arg, v, lab;
        exp_t e;
        mx = 0; arg = 0;
        for (int b = 0; b < len && b < NC; b++) begin
            v = int'(bv[b]);
            if (b == 0 || v > mx) begin mx = v; arg = (b + 1) % NC; end
        end
        if (len == NC) begin
            e.has = (lblq.size() > 0);
            lab   = e.has ? lblq.pop_front() : -1;
            e.cls = LW'(arg);
            e.val = VW'(mx);
            e.cor = e.has && (lab == arg);
            expq.push_back(e);
            m_images++;
            if (e.cor) m_correct++;
        end else begin
            if (lblq.size() > 0) void'(lblq.pop_front());
            m_eb = 1'b1;
        end
        for (int b = 0; b < len; b++) begin
            sif.res_valid = 1'b1;
            sif.res_value = bv[b];
            @(posedge clk); #1;
        end
        sif.res_valid = 1'b0;
    endtask

    task automatic test_drain(input string name);
        nvec++;
        if (expq.size() != 0) begin
            nfail++;
            $display("FAIL %s_drain: got %0d predictions missing, required 0", name, expq.size());
            expq.delete();
        end
    endtask

    task automatic test_stats(input string name);
        @(negedge clk);
        nvec++;
        if ({sif.stat_images, sif.stat_correct, sif.err_burst, sif.err_label_ovf}
            !== {CW'(m_images), CW'(m_correct), m_eb, m_ovf}) begin
            nfail++;
            $display("FAIL %s_stats: got img=%0d cor=%0d eb=%0b ovf=%0b, required img=%0d cor=%0d eb=%0b ovf=%0b",
                     name, sif.stat_images, sif.stat_correct, sif.err_burst, sif.err_label_ovf,
                     m_images, m_correct, m_eb, m_ovf);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sif.res_valid = 1'b0; sif.res_value = '0; sif.label_valid = 1'b0;
        sif.label = '0; sif.clr_stats = 1'b0;
        model_reset();
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if ({sif.pred_valid, sif.pred_class, sif.pred_value, sif.pred_has_label, sif.pred_correct} !== '0) begin
            nfail++;
            $display("FAIL reset_pred: got %0h, required 0",
                     {sif.pred_valid, sif.pred_class, sif.pred_value, sif.pred_has_label, sif.pred_correct});
        end
        nvec++;
        if (sif.label_ready !== 1'b1) begin
            nfail++;
            $display("FAIL reset_label_ready: got %0b, required 1", sif.label_ready);
        end
        test_stats("reset");
    endtask

    task automatic test_basic();
        push_label(3);
        for (int b = 0; b < 16; b++) bv[b] = '0;
        bv[0] = 10'sd5; bv[1] = -10'sd3; bv[2] = 10'sd9; bv[3] = 10'sd9;
        send_burst(NC);
        @(negedge clk);
        nvec++;
        if (sif.pred_valid !== 1'b0) begin
            nfail++; $display("FAIL pulse_early: got %0b, required 0", sif.pred_valid);
        end
        @(negedge clk);
        nvec++;
        if (sif.pred_valid !== 1'b1) begin
            nfail++; $display("FAIL pulse_e1: got %0b, required 1", sif.pred_valid);
        end
        @(negedge clk);
        nvec++;
        if ({sif.pred_valid, sif.pred_class} !== {1'b0, 4'd3}) begin
            nfail++;
            $display("FAIL hold_class: got valid=%0b cls=%0d, required valid=0 cls=3",
                     sif.pred_valid, sif.pred_class);
        end
        test_stats("basic");
        test_drain("basic");
    endtask

    task automatic test_all_min();
        push_label(1);
        for (int b = 0; b < 16; b++) bv[b] = 10'h200;
        send_burst(NC);
        idle(3);
        test_stats("all_min");
        test_drain("all_min");
    endtask

    task automatic test_bad_len();
        push_label(7);
        push_label(8);
        fill(7, 200);
        send_burst(NC - 1);
        idle(2);
        fill(8, 200);
        send_burst(NC + 1);
        idle(3);
        test_stats("bad_len");
        test_drain("bad_len");
        push_label(4);
        fill(4, 150);
        send_burst(NC);
        idle(3);
        test_stats("after_bad");
        test_drain("after_bad");
    endtask

    task automatic test_overflow();
        sif.clr_stats = 1'b1;
        idle(1);
        sif.clr_stats = 1'b0;
        m_images = 0; m_correct = 0; m_eb = 1'b0; m_ovf = 1'b0;
        test_stats("clr");
        for (int k = 0; k < 8; k++) push_label(k);
        @(negedge clk);
        nvec++;
        if (sif.label_ready !== 1'b0) begin
            nfail++; $display("FAIL full_ready: got %0b, required 0", sif.label_ready);
        end
        push_label(8);
        for (int k = 0; k < 8; k++) begin
            fill((k == 5) ? 9 : k, 100 + k);
            send_burst(NC);
            idle(2);
        end
        idle(2);
        test_stats("overflow");
        test_drain("overflow");
    endtask

    task automatic test_no_label_clr();
        fill(6, -20);
        for (int b = 0; b < 16; b++) bv[b] = bv[b] - VW'(100);
        send_burst(NC);
        idle(3);
        test_stats("no_label");
        test_drain("no_label");
        fill(2, 77);
        send_burst(NC);
        idle(1);
        sif.clr_stats = 1'b1;
        idle(1);
        sif.clr_stats = 1'b0;
        m_images = 0; m_correct = 0; m_eb = 1'b0; m_ovf = 1'b0;
        idle(2);
        test_stats("clr_emit");
        test_drain("clr_emit");
    endtask

    task automatic test_back_to_back();
        push_label(2);
        push_label(6);
        fill(2, 300);
        send_burst(NC);
        idle(1);
        fill(6, 300);
        for (int b = 0; b < NC; b++) begin
            sif.res_valid = 1'b1;
            sif.res_value = bv[b];
            rst = (b == 4);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        sif.res_valid = 1'b0;
        model_reset();
        m_eb = 1'b1;
        idle(3);
        test_stats("b2b_reset");
        test_drain("b2b");
        @(negedge clk);
        nvec++;
        if ({sif.pred_class, sif.label_ready} !== {4'd0, 1'b1}) begin
            nfail++;
            $display("FAIL b2b_cleared: got cls=%0d ready=%0b, required cls=0 ready=1",
                     sif.pred_class, sif.label_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_min();
        test_bad_len();
        test_overflow();
        test_no_label_clr();
        test_back_to_back();
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sdfa_argmax_scorer.md
# sdfa_argmax_scorer

Classification back-end of the SDFA inference path. It consumes the per-class output burst (`result_value` / `result_spike_valid`) from `sdfa_top`, picks the signed argmax, and matches it against a queued ground-truth label. It keeps saturating image and correct-prediction counters. This replaces the ad-hoc argmax and scoring logic in simulation with synthesisable, parametrised RTL usable on silicon and FPGA.

## Interface
- `NUM_CLASSES`, 10, beats per result burst (≥2)
- `VALUE_W`, 10, width of signed result value
- `LABEL_W`, 4, class/label width; 2^LABEL_W ≥ NUM_CLASSES
- `ROT`, 1, class mapping: beat b → class (b+ROT) mod NUM_CLASSES; ROT=1 reproduces current SDFA ordering, so the last beat is class 0
- `LBL_DEPTH`, 8, label FIFO depth, power of 2
- `CNT_W`, 16, statistics counter width

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1 — system clock
- `rst` in 1 — synchronous active-high reset
- `res_valid` in 1 — result beat valid; a burst is a contiguous run of high cycles
- `res_value` in VALUE_W — signed class score
- `label_valid` in 1 — push ground-truth label
- `label` in LABEL_W — label value
- `label_ready` out 1 — label FIFO not full
- `clr_stats` in 1 — clear counters and sticky errors
- `pred_valid` out 1 — one-cycle prediction pulse
- `pred_class` out LABEL_W — argmax class
- `pred_value` out VALUE_W — winning score
- `pred_has_label` out 1 — a label was popped for this prediction
- `pred_correct` out 1 — pred_has_label && pred_class == popped label
- `stat_images` out CNT_W — completed valid bursts
- `stat_correct` out CNT_W — correct predictions
- `err_burst` out 1 — sticky: a burst length ≠ NUM_CLASSES
- `err_label_ovf` out 1 — sticky: push while full

## Operation
- States: IDLE, ACCUM, EMIT.
- IDLE: `res_valid`=1 loads beat 0 unconditionally, with `max`=value and `arg`=class(0), sets `beat`=1, and goes to ACCUM.
- ACCUM: each `res_valid`=1 beat with `beat` < NUM_CLASSES replaces `max`/`arg` only if the value is signed-strictly greater, so on ties the earliest beat wins. Beats at or beyond NUM_CLASSES are ignored, but `beat` keeps counting and saturates at NUM_CLASSES+1.
- ACCUM, first `res_valid`=0:
  - If `beat` == NUM_CLASSES, go to EMIT.
  - Otherwise set `err_burst`, pop one label if present, emit nothing, and return to IDLE.
- EMIT: assert `pred_valid` for one cycle, pop the label FIFO head if non-empty, and update the counters. `stat_images`+1, plus `stat_correct`+1 when correct. Both counters saturate at all-ones.
- `res_valid`=1 during EMIT starts a new burst, with the same handling as an IDLE load.
- Label FIFO: a push when full is dropped and sets `err_label_ovf`. Simultaneous push and pop on an empty FIFO: the pop sees empty (no bypass). Simultaneous push and pop on a full FIFO: the push is still rejected, because `label_ready` reflects the full flag only.
- `clr_stats`: zeroes counters and sticky errors. It takes priority over an increment in the same cycle, so that prediction is not counted, but `pred_*` outputs still fire.
- Class computation: (b+ROT) mod NUM_CLASSES, via an incrementing class register with wrap, not a divider.

## Timing
- Latency: last beat sampled on edge E; edge E+1 samples `res_valid`=0; `pred_valid` is high after edge E+1 until edge E+2.
- Counters and FIFO pop update on the same edge that ends EMIT, visible from E+2.
- Minimum inter-burst gap: 1 idle cycle.
- `pred_class`, `pred_value`, `pred_has_label`, `pred_correct` hold until the next EMIT.
- Reset values:
  - all outputs 0, except `label_ready`=1
  - FIFO empty
  - state IDLE
- Reset mid-burst: the partial burst is discarded, and trailing beats after reset form a new (short) burst that sets `err_burst`.

## Structure
- Shared package `sdfa_pkg`: the default NUM_CLASSES, VALUE_W, and LABEL_W constants, and the state enum typedef.
- Sub-module `sdfa_label_fifo`: parametrised synchronous FIFO (DEPTH, WIDTH) with full/empty flags and count, reusable for pixel staging.

## Test plan
- 10-beat burst with values 5,−3,9,9,0,… (defaults, ROT=1), label 3 queued → `pred_class`=3 (beat 2, first 9), `pred_value`=9, `pred_correct`=1, counters 1/1, pulse at E+1.
- All beats = −512 (10'h200) → beat 0 wins, `pred_class`=1, `pred_value`=−512.
- 9-beat burst, then 11-beat burst → no pred_valid, `err_burst`=1, one label popped per burst, `stat_images`=0.
- Push 9 labels with no pop → 9th dropped, `label_ready`=0 after the 8th, `err_label_ovf`=1; 8 subsequent bursts match labels in order.
- Burst with FIFO empty → `pred_has_label`=0, `stat_correct` unchanged, `stat_images`+1; `clr_stats` on the EMIT cycle → both counters 0.
- Back-to-back bursts with a 1-cycle gap, and `rst` asserted on beat 4 → first prediction correct; reset clears all state; trailing 5 beats set `err_burst`.
